tx_serializer_10b: RTL and testbench

Transmit-side parallel-to-serial stage that sits directly downstream of the 8b/10b encoder. It accepts 10-bit line symbols over a valid/ready handshake and shifts them out one bit per clock, bit `a` (index 0) first. When no symbol is offered at a symbol boundary, it inserts a K28.5 comma whose polarity is chosen from its own running-disparity tracker. The same tracker flags disparity violations in the offered symbols.

---
 rtl/line_code_pkg.sv | 23 ++
 rtl/sym_disparity.sv | 32 +++
 rtl/tx_serializer_10b.sv | 83 ++++++++
 tb/tb_tx_serializer_10b.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/line_code_pkg.sv
// Shared 8b/10b line-code definitions for the encoder, transmit serializer and
// the receive-side decoder/aligner.
//   SYM_W      : width of a 10-bit line symbol (bit 0 = a, bit 9 = j)
//   K28_5_RDN  : K28.5 comma transmitted when running disparity is negative
//   K28_5_RDP  : K28.5 comma transmitted when running disparity is positive
//   popcount10 : number of ones in a line symbol
package line_code_pkg;

    localparam int unsigned SYM_W = 10;

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

    function automatic logic [3:0] popcount10(input logic [SYM_W-1:0] s);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < SYM_W; i++) begin
            c = c + {3'b000, s[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sym_disparity.sv
// Combinational running-disparity step for one 10-bit line symbol.
//   sym     : symbol under evaluation
//   rd      : running disparity before the symbol (1 = positive)
//   rd_next : running disparity after the symbol
//   err     : symbol is unbalanced beyond +/-1 or pushes RD further in the
//             direction it already leans
module sym_disparity
    import line_code_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    input  logic             rd,
    output logic             rd_next,
    output logic             err
);

    logic [3:0] n;

    always_comb begin
        n       = popcount10(sym);
        rd_next = rd;
        err     = 1'b0;
        if (n > 4'd5) begin
            // Six ones is legal only from RD-; more than six never is.
            rd_next = 1'b1;
            err     = (n > 4'd6) | rd;
        end else if (n < 4'd5) begin
            rd_next = 1'b0;
            err     = (n < 4'd4) | ~rd;
        end
    end

endmodule

// File: rtl/tx_serializer_10b.sv
// Transmit parallel-to-serial stage behind the 8b/10b encoder. Shifts one
// 10-bit symbol out per ten clocks, LSB (bit a) first, and fills empty symbol
// slots with a K28.5 comma of the polarity demanded by running disparity.
//   clk       : serial bit clock
//   rst       : synchronous active-high reset
//   sym_in    : encoded symbol, bit 0 = a
//   sym_valid : sym_in is offered
//   sym_ready : symbol boundary, sym_in is taken this cycle
//   ser_out   : serial line bit
//   sym_start : bit 0 of a symbol is on ser_out
//   idle_ins  : bit 0 of an inserted comma is on ser_out
//   disp_err  : one-cycle pulse, last loaded data symbol broke disparity rules
//   rd_pos    : current running disparity, 1 = positive
module tx_serializer_10b
    import line_code_pkg::*;
#(
    parameter logic [SYM_W-1:0] IDLE_RDN = K28_5_RDN,
    parameter logic [SYM_W-1:0] IDLE_RDP = K28_5_RDP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             ser_out,
    output logic             sym_start,
    output logic             idle_ins,
    output logic             disp_err,
    output logic             rd_pos
);

    localparam logic [3:0] BIT_LAST = 4'd9;

    logic [SYM_W-1:0] shift_q;
    logic [3:0]       bit_cnt;
    logic             rd_q;
    logic             is_idle_q;
    logic             disp_err_q;

    logic             boundary;
    logic [SYM_W-1:0] load_sym;
    logic             rd_next;
    logic             sym_err;

    assign boundary = (bit_cnt == BIT_LAST);
    assign load_sym = sym_valid ? sym_in : (rd_q ? IDLE_RDP : IDLE_RDN);

    sym_disparity u_disp (
        .sym     (load_sym),
        .rd      (rd_q),
        .rd_next (rd_next),
        .err     (sym_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            bit_cnt    <= BIT_LAST;
            rd_q       <= 1'b0;
            is_idle_q  <= 1'b0;
            disp_err_q <= 1'b0;
        end else if (boundary) begin
            shift_q    <= load_sym;
            bit_cnt    <= 4'd0;
            rd_q       <= rd_next;
            is_idle_q  <= ~sym_valid;
            // The comma is chosen from RD, so it can never be in error.
            disp_err_q <= sym_valid & sym_err;
        end else begin
            shift_q    <= shift_q >> 1;
            bit_cnt    <= bit_cnt + 4'd1;
            disp_err_q <= 1'b0;
        end
    end

    assign ser_out   = shift_q[0];
    assign sym_ready = boundary;
    assign sym_start = (bit_cnt == 4'd0);
    assign idle_ins  = sym_start & is_idle_q;
    assign disp_err  = disp_err_q;
    assign rd_pos    = rd_q;

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Scoreboard bench for tx_serializer_10b: a driver offers scripted and random
// symbols, a reference model predicts every line symbol at each slot, and a
// monitor reassembles the serial stream and checks it against the queue.
module tb_tx_serializer_10b;

    localparam logic [9:0] RDN = 10'h17C;
    localparam logic [9:0] RDP = 10'h283;

    typedef struct {
        logic [9:0] sym;
        bit         idle;
        bit         rd;
        bit         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sym_in = 10'd0;
    logic       sym_valid = 1'b0;
    logic       sym_ready, ser_out, sym_start, idle_ins, disp_err, rd_pos;

    int checks = 0;
    int failures = 0;
    int nsyms = 0;

    exp_t    exp_q[$];
    bit [10:0] script_q[$];  // {valid, symbol} per symbol slot
    int      phase_m = 9;    // cycles into the current slot, per the model
    bit      rd_m = 1'b0;
    bit      taken = 1'b0;
    bit      rand_en = 1'b0;

    tx_serializer_10b dut (
        .clk       (clk),
        .rst       (rst),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .ser_out   (ser_out),
        .sym_start (sym_start),
        .idle_ins  (idle_ins),
        .disp_err  (disp_err),
        .rd_pos    (rd_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] rand_sym();
        logic [9:0] s;
        s = 10'($urandom);
        if ($urandom_range(0, 4) != 0) begin
            for (int k = 0; k < 50; k++) begin
                if ($countones(s) >= 4 && $countones(s) <= 6) break;
                s = 10'($urandom);
            end
        end
        return s;
    endfunction

    // Reference model: one symbol slot every ten cycles from reset release.
    always @(posedge clk) begin
        exp_t e;
        int   n;
        if (rst) begin
            rd_m    = 1'b0;
            phase_m = 9;
        end else if (phase_m == 9) begin
            e.idle = !sym_valid;
            e.sym  = sym_valid ? sym_in : (rd_m ? RDP : RDN);
            n      = $countones(e.sym);
            e.err  = !e.idle && !(n == 5 || (n == 6 && !rd_m) || (n == 4 && rd_m));
            if (n > 5) rd_m = 1'b1;
            else if (n < 5) rd_m = 1'b0;
            e.rd = rd_m;
            exp_q.push_back(e);
            taken   = sym_valid;
            phase_m = 0;
        end else begin
            phase_m++;
        end
    end

    // Driver: upstream holds an offered symbol until it is taken.
    always @(negedge clk) begin
        bit [10:0] s;
        if (taken) begin
            taken     = 1'b0;
            sym_valid = 1'b0;
        end
        if (phase_m == 9 && script_q.size() > 0) begin
            s         = script_q.pop_front();
            sym_valid = s[10];
            sym_in    = s[9:0];
        end else if (rand_en && !sym_valid && script_q.size() == 0 &&
                     $urandom_range(0, 3) == 0) begin
            sym_valid = 1'b1;
            sym_in    = rand_sym();
        end
    end

    // Monitor: reassembles each serial symbol and pops its prediction.
    initial begin
        exp_t       cur;
        int         bit_idx = 10;
        logic [9:0] word = 10'd0;
        bit         have = 1'b0;
        cur.sym = 10'd0; cur.idle = 1'b0; cur.rd = 1'b0; cur.err = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                chk("rst_ser_out",   10'(ser_out),   10'd0);
                chk("rst_sym_ready", 10'(sym_ready), 10'd1);
                chk("rst_sym_start", 10'(sym_start), 10'd0);
                chk("rst_idle_ins",  10'(idle_ins),  10'd0);
                chk("rst_disp_err",  10'(disp_err),  10'd0);
                chk("rst_rd_pos",    10'(rd_pos),    10'd0);
                exp_q.delete();
                bit_idx = 10;
                have    = 1'b0;
                continue;
            end
            if (sym_start) begin
                chk("slot_gap", 10'(bit_idx), 10'd10);
                if (exp_q.size() == 0) begin
                    chk("unexpected_symbol", 10'd1, 10'd0);
                    have = 1'b0;
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                    nsyms++;
                    chk("idle_ins", 10'(idle_ins), 10'(cur.idle));
                    chk("disp_err", 10'(disp_err), 10'(cur.err));
                end
                bit_idx = 0;
                word    = 10'd0;
            end else begin
                chk("idle_ins_mid", 10'(idle_ins), 10'd0);
                chk("disp_err_mid", 10'(disp_err), 10'd0);
            end
            if (have) chk("rd_pos", 10'(rd_pos), 10'(cur.rd));
            if (bit_idx < 10) begin
                word[bit_idx] = ser_out;
                bit_idx++;
                if (bit_idx == 10 && have) chk("symbol_bits", word, cur.sym);
            end
            chk("sym_ready", 10'(sym_ready), 10'(bit_idx == 10));
        end
    end

    initial begin
        int budget;
        // Two idles after reset, then contiguous data, then disparity errors.
        script_q.push_back({1'b0, 10'h000});
        script_q.push_back({1'b0, 10'h000});
        script_q.push_back({1'b1, 10'h155});
        script_q.push_back({1'b1, 10'h155});
        script_q.push_back({1'b1, 10'h17C});
        script_q.push_back({1'b1, 10'h283});
        script_q.push_back({1'b1, 10'h3FF});
        script_q.push_back({1'b1, 10'h17C});
        script_q.push_back({1'b0, 10'h000});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        budget = 0;
        while (script_q.size() > 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        chk("script_drained", 10'(script_q.size()), 10'd0);
        rand_en = 1'b1;
        repeat (600) @(negedge clk);

        // Reset while bit 4 of a symbol is on the line.
        budget = 0;
        while (phase_m != 4 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("found_bit4", 10'(phase_m), 10'd4);
        rand_en = 1'b0;
        rst = 1'b1;
        script_q.push_back({1'b0, 10'h000});
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        rand_en = 1'b1;
        repeat (400) @(negedge clk);

        chk("symbols_seen", 10'(nsyms > 100), 10'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
